de_selector_scan: RTL and testbench

Registered, parametrised 1-to-N de-selector with active-low outputs and an auto-scan mode.
- Routes data bit `iC` to one of N = 2^SEL_W outputs `oZ`. The selected output goes low only when `iC`=0; every other output stays high.
- Channel selection comes either from `iSel` (manual mode) or from an internal scan counter that steps through all channels, dwelling SCAN_DIV cycles on each (scan mode).
- Sits in the same output-drive path as the existing combinational 1-to-4 de-selector. It replaces that block where registered outputs, wider fan-out or time-multiplexed scanning are needed.

---
 rtl/de_selector_scan.sv | 109 ++++++++++
 tb/tb_de_selector_scan.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/de_selector_scan.sv
// Registered 1-to-N de-selector with active-low outputs and an auto-scan mode.
// The channel is taken from iSel (manual) or from an internal scan counter
// that dwells SCAN_DIV cycles per channel. Every output comes straight from a flop.
module de_selector_scan #(
    parameter int SEL_W    = 2,
    parameter int SCAN_DIV = 4
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iC,
    input  logic [SEL_W-1:0]         iSel,
    input  logic                     iMode,
    input  logic                     iEn,
    output logic [(1<<SEL_W)-1:0]    oZ,
    output logic [SEL_W-1:0]         oSel,
    output logic                     oWrap
);

    localparam int N     = 1 << SEL_W;
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(N - 1);
    localparam logic [SEL_W-1:0] SEL_ONE = SEL_W'(1);

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] w_sel_next;
    logic [N-1:0]     r_z;
    logic [N-1:0]     w_z_next;
    logic             r_wrap;
    logic             w_wrap_next;

    // State register: MANUAL out of reset.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state <= ST_MANUAL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state follows iMode while enabled; a disabled block holds its state.
    always_comb begin
        w_state_next = r_state;
        if (iEn) begin
            w_state_next = iMode ? ST_SCAN : ST_MANUAL;
        end
    end

    // Next selection, prescaler and wrap flag. Entering scan keeps the last
    // manual channel and restarts the dwell so it gets a full SCAN_DIV cycles.
    always_comb begin
        w_sel_next  = r_sel;
        w_cnt_next  = r_cnt;
        w_wrap_next = 1'b0;
        if (iEn) begin
            if (w_state_next == ST_MANUAL) begin
                w_sel_next = iSel;
                w_cnt_next = '0;
            end else if (r_state == ST_MANUAL) begin
                w_cnt_next = '0;
            end else if (r_cnt == CNT_MAX) begin
                w_cnt_next  = '0;
                w_sel_next  = r_sel + SEL_ONE;
                w_wrap_next = (r_sel == SEL_MAX);
            end else begin
                w_cnt_next = r_cnt + CNT_ONE;
            end
        end
    end

    // Active-low decode of the new selection; a disabled block drives all ones.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_decode
            assign w_z_next[gi] = ~(iEn & ~iC & (w_sel_next == SEL_W'(gi)));
        end
    endgenerate

    // Output and datapath registers, updated together so oZ and oSel always agree.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_z    <= '1;
            r_sel  <= '0;
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_z    <= w_z_next;
            r_sel  <= w_sel_next;
            r_cnt  <= w_cnt_next;
            r_wrap <= w_wrap_next;
        end
    end

    assign oZ    = r_z;
    assign oSel  = r_sel;
    assign oWrap = r_wrap;

endmodule

// File: tb/tb_de_selector_scan.sv
// Scoreboard bench for de_selector_scan (SEL_W=2, SCAN_DIV=3).
// Stimulus pushes hand-computed expectations; a monitor pops and compares them.
module tb_de_selector_scan;

    localparam int SEL_W    = 2;
    localparam int SCAN_DIV = 3;
    localparam int N        = 4;

    logic             iClk = 1'b0;
    logic             iRst;
    logic             iC;
    logic [SEL_W-1:0] iSel;
    logic             iMode;
    logic             iEn;
    logic [N-1:0]     oZ;
    logic [SEL_W-1:0] oSel;
    logic             oWrap;

    typedef struct packed {
        logic [N-1:0]     z;
        logic [SEL_W-1:0] sel;
        logic             wrap;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pushed = 0;

    de_selector_scan #(
        .SEL_W   (SEL_W),
        .SCAN_DIV(SCAN_DIV)
    ) dut (
        .iClk (iClk),
        .iRst (iRst),
        .iC   (iC),
        .iSel (iSel),
        .iMode(iMode),
        .iEn  (iEn),
        .oZ   (oZ),
        .oSel (oSel),
        .oWrap(oWrap)
    );

    always #5 iClk = ~iClk;

    task automatic push_exp(input logic [N-1:0] z, input logic [SEL_W-1:0] sel, input logic wrap);
        exp_t e;
        e.z    = z;
        e.sel  = sel;
        e.wrap = wrap;
        exp_q.push_back(e);
        pushed++;
    endtask

    // Drive one cycle of inputs, then record what the outputs must show after the edge.
    task automatic cyc(input logic c, input logic [SEL_W-1:0] sel, input logic mode, input logic en,
                       input logic [N-1:0] ez, input logic [SEL_W-1:0] esel, input logic ew);
        iC    = c;
        iSel  = sel;
        iMode = mode;
        iEn   = en;
        @(posedge iClk);
        #1;
        push_exp(ez, esel, ew);
    endtask

    // Monitor: outputs are compared away from the rising edge, and also just after
    // a reset assertion so an asynchronous reset is checked before any clock edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge iClk or posedge iRst);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (oZ !== e.z || oSel !== e.sel || oWrap !== e.wrap) begin
                    errors++;
                    $display("FAIL txn%0d: got oZ=%b oSel=%0d oWrap=%b, want oZ=%b oSel=%0d oWrap=%b",
                             checks, oZ, oSel, oWrap, e.z, e.sel, e.wrap);
                end else begin
                    $display("txn%0d ok: oZ=%b oSel=%0d oWrap=%b", checks, oZ, oSel, oWrap);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        // Reset held with arbitrary inputs.
        iRst = 1'b1;
        cyc(1'($urandom), 2'($urandom), 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0);
        cyc(1'($urandom), 2'($urandom), 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0);
        iRst = 1'b0;

        // Manual decode; first edge after release decodes normally.
        cyc(1'b0, 2'd2, 1'b0, 1'b1, 4'b1011, 2'd2, 1'b0);
        cyc(1'b1, 2'd2, 1'b0, 1'b1, 4'b1111, 2'd2, 1'b0);
        cyc(1'b0, 2'd0, 1'b0, 1'b1, 4'b1110, 2'd0, 1'b0);
        cyc(1'b0, 2'd1, 1'b0, 1'b1, 4'b1101, 2'd1, 1'b0);
        cyc(1'b0, 2'd2, 1'b0, 1'b1, 4'b1011, 2'd2, 1'b0);
        cyc(1'b0, 2'd3, 1'b0, 1'b1, 4'b0111, 2'd3, 1'b0);

        // Scan from manual channel 1; iSel is ignored in scan.
        cyc(1'b0, 2'd1, 1'b0, 1'b1, 4'b1101, 2'd1, 1'b0);
        cyc(1'b0, 2'd3, 1'b1, 1'b1, 4'b1101, 2'd1, 1'b0);
        cyc(1'b0, 2'd3, 1'b1, 1'b1, 4'b1101, 2'd1, 1'b0);
        cyc(1'b0, 2'd3, 1'b1, 1'b1, 4'b1101, 2'd1, 1'b0);
        cyc(1'b0, 2'd3, 1'b1, 1'b1, 4'b1011, 2'd2, 1'b0);
        cyc(1'b0, 2'd3, 1'b1, 1'b1, 4'b1011, 2'd2, 1'b0);
        cyc(1'b0, 2'd3, 1'b1, 1'b1, 4'b1011, 2'd2, 1'b0);
        cyc(1'b0, 2'd3, 1'b1, 1'b1, 4'b0111, 2'd3, 1'b0);
        cyc(1'b0, 2'd3, 1'b1, 1'b1, 4'b0111, 2'd3, 1'b0);
        cyc(1'b0, 2'd3, 1'b1, 1'b1, 4'b0111, 2'd3, 1'b0);
        cyc(1'b0, 2'd3, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b1);
        cyc(1'b0, 2'd3, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0);
        cyc(1'b0, 2'd3, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0);
        cyc(1'b0, 2'd3, 1'b1, 1'b1, 4'b1101, 2'd1, 1'b0);
        cyc(1'b0, 2'd3, 1'b1, 1'b1, 4'b1101, 2'd1, 1'b0);
        cyc(1'b0, 2'd3, 1'b1, 1'b1, 4'b1101, 2'd1, 1'b0);
        cyc(1'b0, 2'd3, 1'b1, 1'b1, 4'b1011, 2'd2, 1'b0);
        cyc(1'b0, 2'd3, 1'b1, 1'b1, 4'b1011, 2'd2, 1'b0);

        // Freeze in the 2nd dwell cycle of channel 2; iSel and iMode ignored.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 2'd0, 1'b0, 1'b0, 4'b1111, 2'd2, 1'b0);
        end
        cyc(1'b0, 2'd3, 1'b1, 1'b1, 4'b1011, 2'd2, 1'b0);
        cyc(1'b0, 2'd3, 1'b1, 1'b1, 4'b0111, 2'd3, 1'b0);

        // Mode exit at channel 3, then re-entry dwells a full 3 cycles.
        cyc(1'b0, 2'd1, 1'b0, 1'b1, 4'b1101, 2'd1, 1'b0);
        cyc(1'b0, 2'd0, 1'b1, 1'b1, 4'b1101, 2'd1, 1'b0);
        cyc(1'b0, 2'd0, 1'b1, 1'b1, 4'b1101, 2'd1, 1'b0);
        cyc(1'b0, 2'd0, 1'b1, 1'b1, 4'b1101, 2'd1, 1'b0);
        cyc(1'b0, 2'd0, 1'b1, 1'b1, 4'b1011, 2'd2, 1'b0);
        cyc(1'b0, 2'd0, 1'b1, 1'b1, 4'b1011, 2'd2, 1'b0);
        cyc(1'b1, 2'd0, 1'b1, 1'b1, 4'b1111, 2'd2, 1'b0);
        cyc(1'b0, 2'd0, 1'b1, 1'b1, 4'b0111, 2'd3, 1'b0);

        // Manual load of 0 never raises oWrap.
        cyc(1'b0, 2'd0, 1'b0, 1'b1, 4'b1110, 2'd0, 1'b0);

        // Async reset mid-scan, asserted between edges.
        cyc(1'b0, 2'd3, 1'b0, 1'b1, 4'b0111, 2'd3, 1'b0);
        cyc(1'b0, 2'd3, 1'b1, 1'b1, 4'b0111, 2'd3, 1'b0);
        @(negedge iClk);
        #2;
        iRst = 1'b1;
        push_exp(4'b1111, 2'd0, 1'b0);
        cyc(1'b0, 2'd2, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0);
        iRst = 1'b0;
        cyc(1'b0, 2'd1, 1'b0, 1'b1, 4'b1101, 2'd1, 1'b0);

        // Drain the scoreboard with a bounded wait.
        repeat (3) @(negedge iClk);
        #2;
        if (exp_q.size() != 0 || checks != pushed) begin
            errors++;
            $display("FAIL drain: checked %0d of %0d expectations, %0d left", checks, pushed, exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
